// File: rtl/uart_bus_pkg.sv
// uart_bus_pkg: shared opcodes, response byte, FSM states and default bit timing for the UART bus master.
package uart_bus_pkg;
    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h4B;
    localparam int DEFAULT_CLKS_PER_BIT = 10417;
    typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;
endpackage

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 receiver with input synchronizer, glitch-checked start bit and mid-bit sampling.
module uart_byte_rx
    import uart_bus_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       active
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [1:0] S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3;
    logic [1:0] st;
    logic s1, s2, s3;
    logic [CW-1:0] cnt;
    logic [2:0] idx;
    logic last;
    assign last = cnt == CW'(CLKS_PER_BIT - 1);
    assign byte_valid = st == S_STOP && last && s2;
    assign frame_err = st == S_STOP && last && !s2;
    assign active = st != S_IDLE;
    always_ff @(posedge clk) begin
        if (reset) begin
            st <= S_IDLE;
            {s1, s2, s3} <= 3'b111;
            cnt <= '0;
            idx <= '0;
            data <= '0;
        end else begin
            {s1, s2, s3} <= {rx, s1, s2};
            case (st)
                S_IDLE: begin
                    cnt <= '0;
                    if (s3 && !s2) st <= S_START;
                end
                S_START: begin
                    cnt <= cnt + 1'b1;
                    // a start bit that is no longer low at half-bit is a glitch
                    if (cnt == CW'(CLKS_PER_BIT / 2 - 1)) begin
                        cnt <= '0;
                        idx <= '0;
                        st <= s2 ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    cnt <= last ? '0 : cnt + 1'b1;
                    if (last) begin
                        data <= {s2, data[7:1]};
                        idx <= idx + 1'b1;
                        if (idx == 3'd7) st <= S_STOP;
                    end
                end
                S_STOP: begin
                    cnt <= last ? '0 : cnt + 1'b1;
                    if (last) st <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: rtl/uart_bus_master.sv
// uart_bus_master: UART command decoder issuing 32-bit bus reads/writes and serialising the response.
module uart_bus_master
    import uart_bus_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int TIMEOUT_BITS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        rd,
    output logic        wr,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW = $clog2(LIMIT);
    state_t state;
    logic op_wr;
    logic [1:0] nbytes, resp_left;
    logic [23:0] sh;
    logic [31:0] resp_buf;
    logic [8:0] tx_sh;
    logic [3:0] tx_bit;
    logic [CW-1:0] tx_cnt;
    logic [TW-1:0] timer;
    logic [7:0] rx_data;
    logic byte_valid, frame_err, rx_active, bit_end;

    uart_byte_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk(clk), .reset(reset), .rx(uart_rx), .data(rx_data),
        .byte_valid(byte_valid), .frame_err(frame_err), .active(rx_active)
    );

    assign rd = state == BUS && !op_wr;
    assign wr = state == BUS && op_wr;
    assign busy = state != IDLE;
    assign bit_end = tx_cnt == CW'(CLKS_PER_BIT - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            op_wr <= 1'b0;
            nbytes <= '0;
            resp_left <= '0;
            sh <= '0;
            addr <= '0;
            wdata <= '0;
            resp_buf <= '0;
            tx_sh <= '0;
            tx_bit <= '0;
            tx_cnt <= '0;
            timer <= '0;
            uart_tx <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    timer <= '0;
                    nbytes <= '0;
                    if (byte_valid && (rx_data == OP_WRITE || rx_data == OP_READ)) begin
                        state <= ADDR;
                        op_wr <= rx_data == OP_WRITE;
                    end
                end
                ADDR, DATA: begin
                    timer <= rx_active ? '0 : timer + 1'b1;
                    if (frame_err || (!rx_active && timer == TW'(LIMIT - 1))) state <= IDLE;
                    else if (byte_valid) begin
                        // bytes assemble in sh so addr/wdata only change on a complete field
                        sh <= {sh[15:0], rx_data};
                        nbytes <= nbytes + 1'b1;
                        if (nbytes == 2'd3 && state == ADDR) begin
                            addr <= {sh, rx_data};
                            state <= op_wr ? DATA : BUS;
                        end else if (nbytes == 2'd3) begin
                            wdata <= {sh, rx_data};
                            state <= BUS;
                        end
                    end
                end
                BUS: begin
                    uart_tx <= 1'b0;
                    tx_sh <= {1'b1, op_wr ? RSP_ACK : rdata[31:24]};
                    resp_buf <= {rdata[23:0], 8'h00};
                    resp_left <= op_wr ? 2'd0 : 2'd3;
                    tx_cnt <= '0;
                    tx_bit <= '0;
                    state <= RESP;
                end
                RESP: begin
                    tx_cnt <= bit_end ? '0 : tx_cnt + 1'b1;
                    if (bit_end && tx_bit == 4'd9 && resp_left == 2'd0) state <= IDLE;
                    else if (bit_end && tx_bit == 4'd9) begin
                        uart_tx <= 1'b0;
                        tx_sh <= {1'b1, resp_buf[31:24]};
                        resp_buf <= resp_buf << 8;
                        resp_left <= resp_left - 1'b1;
                        tx_bit <= '0;
                    end else if (bit_end) begin
                        uart_tx <= tx_sh[0];
                        tx_sh <= tx_sh >> 1;
                        tx_bit <= tx_bit + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_bus_master.sv
// tb_uart_bus_master: directed command sequences with a serial response decoder and bus strobe monitor.
module tb_uart_bus_master;
    localparam int CPB = 16;
    logic clk = 1'b0, reset = 1'b1, uart_rx = 1'b1;
    logic uart_tx, rd, wr, busy;
    logic [31:0] addr, wdata, rdata;
    int tests = 0, fails = 0;
    int wr_cnt = 0, rd_cnt = 0, both_cnt = 0;
    logic [31:0] wr_addr = '0, wr_data = '0, rd_addr = '0;
    logic [7:0] rx_q[$];

    always #5 clk = ~clk;
    assign rdata = (addr == 32'h40000010) ? 32'h12345678 : 32'hDEADBEEF;

    uart_bus_master #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(64)) dut (
        .clk(clk), .reset(reset), .uart_rx(uart_rx), .uart_tx(uart_tx), .rd(rd), .wr(wr),
        .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy)
    );

    always @(negedge clk) begin
        if (wr) begin
            wr_cnt++;
            wr_addr = addr;
            wr_data = wdata;
        end
        if (rd) begin
            rd_cnt++;
            rd_addr = addr;
        end
        if (rd && wr) both_cnt++;
    end

    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (!reset && uart_tx === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = uart_tx;
                end
                repeat (CPB) @(negedge clk);
                rx_q.push_back(b);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] qb(input int i);
        return (i < rx_q.size()) ? rx_q[i] : 8'hxx;
    endfunction

    task automatic send_byte(input logic [7:0] v, input logic stop);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = v[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic send_bytes(input logic [71:0] v, input int n);
        for (int k = n - 1; k >= 0; k--) send_byte(v[k*8 +: 8], 1'b1);
    endtask

    task automatic wait_resp(input string tag, input int n);
        int c = 0;
        while (rx_q.size() < n && c < CPB * 10 * n + 400) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_resp_count"}, rx_q.size(), n);
    endtask

    task automatic wait_idle(input string tag);
        int c = 0;
        while (busy !== 1'b0 && c < 400) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_busy_drop"}, busy, 1'b0);
    endtask

    task automatic clear();
        wr_cnt = 0;
        rd_cnt = 0;
        rx_q.delete();
    endtask

    initial begin
        repeat (4) @(negedge clk);
        check("rst_uart_tx", uart_tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_rd", rd, 1'b0);
        check("rst_wr", wr, 1'b0);
        check("rst_addr", addr, 32'h0);
        check("rst_wdata", wdata, 32'h0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        send_bytes(72'h57_40_00_00_0C_00_00_00_A5, 9);
        wait_resp("wr", 1);
        wait_idle("wr");
        check("wr_pulses", wr_cnt, 1);
        check("wr_no_rd", rd_cnt, 0);
        check("wr_addr", wr_addr, 32'h4000000C);
        check("wr_wdata", wr_data, 32'h000000A5);
        check("wr_ack", qb(0), 8'h4B);
        check("wr_addr_hold", addr, 32'h4000000C);
        check("wr_wdata_hold", wdata, 32'h000000A5);

        clear();
        send_bytes(72'h52_40_00_00_10, 5);
        wait_resp("rd", 4);
        wait_idle("rd");
        check("rd_pulses", rd_cnt, 1);
        check("rd_no_wr", wr_cnt, 0);
        check("rd_addr", rd_addr, 32'h40000010);
        check("rd_byte0", qb(0), 8'h12);
        check("rd_byte1", qb(1), 8'h34);
        check("rd_byte2", qb(2), 8'h56);
        check("rd_byte3", qb(3), 8'h78);

        clear();
        send_bytes(72'h00_FF_52_40_00_00_10, 7);
        wait_resp("garbage", 4);
        wait_idle("garbage");
        check("garbage_rd_pulses", rd_cnt, 1);
        check("garbage_byte0", qb(0), 8'h12);
        check("garbage_byte3", qb(3), 8'h78);
        check("garbage_resp_total", rx_q.size(), 4);

        clear();
        send_bytes(72'h57_40_00, 3);
        check("timeout_busy_before", busy, 1'b1);
        repeat (1100) @(negedge clk);
        check("timeout_busy_after", busy, 1'b0);
        check("timeout_no_wr", wr_cnt, 0);
        check("timeout_addr_hold", addr, 32'h40000010);
        check("timeout_no_resp", rx_q.size(), 0);
        send_bytes(72'h57_40_00_00_20_11_22_33_44, 9);
        wait_resp("after_timeout", 1);
        wait_idle("after_timeout");
        check("after_timeout_wr_pulses", wr_cnt, 1);
        check("after_timeout_addr", wr_addr, 32'h40000020);
        check("after_timeout_wdata", wr_data, 32'h11223344);
        check("after_timeout_ack", qb(0), 8'h4B);

        clear();
        send_bytes(72'h57_40, 2);
        send_byte(8'h00, 1'b0);
        repeat (4) @(negedge clk);
        check("ferr_busy", busy, 1'b0);
        repeat (400) @(negedge clk);
        check("ferr_no_wr", wr_cnt, 0);
        check("ferr_no_rd", rd_cnt, 0);
        check("ferr_no_resp", rx_q.size(), 0);

        clear();
        send_bytes(72'h52_40_00_00_10, 5);
        wait_resp("rst_mid", 1);
        repeat (40) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_uart_tx", uart_tx, 1'b1);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_rd", rd, 1'b0);
        check("rst_mid_wr", wr, 1'b0);
        check("rst_mid_addr", addr, 32'h0);
        check("rst_mid_rd_pulses", rd_cnt, 1);
        check("never_rd_and_wr", both_cnt, 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
